// File: rtl/ghost_collision_monitor_pkg.sv
// ghost_collision_monitor_pkg: shared screen geometry, direction codes and monitor state encodings.
package ghost_collision_monitor_pkg;
  localparam int WIDTH = 640;
  localparam int HEIGHT = 480;
  localparam int width_log2 = 10;
  localparam int height_log2 = 9;
  localparam logic [1:0] dir_up = 2'd0;
  localparam logic [1:0] dir_down = 2'd1;
  localparam logic [1:0] dir_left = 2'd2;
  localparam logic [1:0] dir_right = 2'd3;
  typedef enum logic [1:0] {
    mon_play   = 2'd0,
    mon_freeze = 2'd1,
    mon_over   = 2'd2
  } mon_state_e;
  // Codes are paired (up/down, left/right) so flipping bit 0 gives the opposite.
  function automatic logic [1:0] opp_dir(input logic [1:0] d);
    return d ^ 2'b01;
  endfunction
endpackage

// File: rtl/ghost_hit_check.sv
// ghost_hit_check: same-tile compare for one ghost; with GHOST_CROSS_DETECT_EN also the pass-through test.
module ghost_hit_check
  import ghost_collision_monitor_pkg::*;
(
  input  logic [width_log2-1:0]  ghost_x,
  input  logic [height_log2-1:0] ghost_y,
  input  logic [width_log2-1:0]  player_x,
  input  logic [height_log2-1:0] player_y,
`ifdef GHOST_CROSS_DETECT_EN
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   upd,
  input  logic                   clr,
  input  logic [1:0]             ghost_dir,
  input  logic [1:0]             player_opp,
  input  logic [width_log2-1:0]  player_px,
  input  logic [height_log2-1:0] player_py,
  input  logic                   player_vld,
`endif
  output logic                   hit
);
  logic same;
  assign same = ghost_x == player_x && ghost_y == player_y;
`ifdef GHOST_CROSS_DETECT_EN
  logic [width_log2-1:0] prev_x_q, prev_x_d;
  logic [height_log2-1:0] prev_y_q, prev_y_d;
  logic vld_q, vld_d;
  always_comb begin
    prev_x_d = upd ? ghost_x : prev_x_q;
    prev_y_d = upd ? ghost_y : prev_y_q;
    vld_d = clr ? 1'b0 : upd ? 1'b1 : vld_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_x_q <= '0;
      prev_y_q <= '0;
      vld_q <= 1'b0;
    end else begin
      prev_x_q <= prev_x_d;
      prev_y_q <= prev_y_d;
      vld_q <= vld_d;
    end
  end
  // Ghost and player swapped tiles this step while heading toward each other.
  assign hit = same || (vld_q && player_vld && prev_x_q == player_x && prev_y_q == player_y &&
                        player_px == ghost_x && player_py == ghost_y && ghost_dir == player_opp);
`else
  assign hit = same;
`endif
endmodule

// File: rtl/ghost_collision_monitor.sv
// ghost_collision_monitor: catch detection, lives, freeze/respawn sequencing and game-over latch.
// Optional pass-through detection is enabled by defining GHOST_CROSS_DETECT_EN.
module ghost_collision_monitor
  import ghost_collision_monitor_pkg::*;
#(
  parameter int NUM_GHOSTS = 4,
  parameter int LIVES = 3,
  parameter int FREEZE_STEPS = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              step,
  input  logic                              restart,
  input  logic [width_log2-1:0]             player_x,
  input  logic [height_log2-1:0]            player_y,
  input  logic [NUM_GHOSTS*width_log2-1:0]  ghost_x,
  input  logic [NUM_GHOSTS*height_log2-1:0] ghost_y,
  input  logic [2*NUM_GHOSTS-1:0]           ghost_direction,
  output logic [1:0]                        lives,
  output logic                              caught,
  output logic [1:0]                        caught_id,
  output logic [NUM_GHOSTS-1:0]             caught_mask,
  output logic                              freeze,
  output logic                              respawn,
  output logic                              game_over
);
  mon_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] lives_q, lives_d, caught_id_q, caught_id_d, first_id;
  logic caught_q, caught_d, respawn_q, respawn_d, play_step;
  logic [NUM_GHOSTS-1:0] caught_mask_q, caught_mask_d, hit;
  assign play_step = step && state_q == mon_play;
`ifdef GHOST_CROSS_DETECT_EN
  logic [width_log2-1:0] player_px_q, player_px_d;
  logic [height_log2-1:0] player_py_q, player_py_d;
  logic player_vld_q, player_vld_d;
  logic [1:0] player_opp;
  always_comb begin
    player_px_d = play_step ? player_x : player_px_q;
    player_py_d = play_step ? player_y : player_py_q;
    player_vld_d = respawn_d ? 1'b0 : play_step ? 1'b1 : player_vld_q;
    player_opp = opp_dir(player_x > player_px_q ? dir_right : player_x < player_px_q ? dir_left :
                         player_y > player_py_q ? dir_down : dir_up);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      player_px_q <= '0;
      player_py_q <= '0;
      player_vld_q <= 1'b0;
    end else begin
      player_px_q <= player_px_d;
      player_py_q <= player_py_d;
      player_vld_q <= player_vld_d;
    end
  end
`else
  logic unused_dir;
  assign unused_dir = ^ghost_direction;
`endif
  for (genvar i = 0; i < NUM_GHOSTS; i++) begin : g_hit
    ghost_hit_check u_hit (
      .ghost_x   (ghost_x[i*width_log2 +: width_log2]),
      .ghost_y   (ghost_y[i*height_log2 +: height_log2]),
      .player_x  (player_x),
      .player_y  (player_y),
`ifdef GHOST_CROSS_DETECT_EN
      .clk       (clk),
      .reset     (reset),
      .upd       (play_step),
      .clr       (respawn_d),
      .ghost_dir (ghost_direction[2*i +: 2]),
      .player_opp(player_opp),
      .player_px (player_px_q),
      .player_py (player_py_q),
      .player_vld(player_vld_q),
`endif
      .hit       (hit[i])
    );
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    lives_d = lives_q;
    caught_d = 1'b0;
    respawn_d = 1'b0;
    caught_id_d = caught_id_q;
    caught_mask_d = caught_mask_q;
    first_id = 2'd0;
    for (int i = NUM_GHOSTS - 1; i >= 0; i--) if (hit[i]) first_id = 2'(i);
    case (state_q)
      mon_play: if (step && |hit) begin
        lives_d = lives_q - 2'd1;
        caught_d = 1'b1;
        caught_id_d = first_id;
        caught_mask_d = hit;
        state_d = lives_q == 2'd1 ? mon_over : mon_freeze;
        cnt_d = 4'(FREEZE_STEPS - 1);
      end
      mon_freeze: if (step) begin
        respawn_d = cnt_q == 4'd0;
        state_d = cnt_q == 4'd0 ? mon_play : mon_freeze;
        cnt_d = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
      end
      default: if (restart) begin
        lives_d = 2'(LIVES);
        respawn_d = 1'b1;
        state_d = mon_play;
      end
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= mon_play;
      cnt_q <= 4'd0;
      lives_q <= 2'(LIVES);
      caught_q <= 1'b0;
      respawn_q <= 1'b0;
      caught_id_q <= 2'd0;
      caught_mask_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      lives_q <= lives_d;
      caught_q <= caught_d;
      respawn_q <= respawn_d;
      caught_id_q <= caught_id_d;
      caught_mask_q <= caught_mask_d;
    end
  end
  assign lives = lives_q;
  assign caught = caught_q;
  assign caught_id = caught_id_q;
  assign caught_mask = caught_mask_q;
  assign respawn = respawn_q;
  assign freeze = state_q == mon_freeze;
  assign game_over = state_q == mon_over;
endmodule

// File: tb/tb_ghost_collision_monitor.sv
// tb_ghost_collision_monitor: scoreboard bench with a behavioural game model; honours GHOST_CROSS_DETECT_EN.
module tb_ghost_collision_monitor;
  import ghost_collision_monitor_pkg::*;
  localparam int NG = 4;
  localparam int LV = 3;
  localparam int FS = 4;
`ifdef GHOST_CROSS_DETECT_EN
  localparam int CROSS = 1;
`else
  localparam int CROSS = 0;
`endif
  typedef struct packed {
    logic [1:0] lives;
    logic caught;
    logic [1:0] id;
    logic [NG-1:0] mask;
    logic frz;
    logic rsp;
    logic ovr;
  } exp_t;
  logic clk = 0, reset = 1, step = 0, restart = 0;
  logic [width_log2-1:0] player_x = '0;
  logic [height_log2-1:0] player_y = '0;
  logic [NG*width_log2-1:0] ghost_x = '0;
  logic [NG*height_log2-1:0] ghost_y = '0;
  logic [2*NG-1:0] ghost_direction = '0;
  logic [1:0] lives, caught_id;
  logic caught, freeze, respawn, game_over;
  logic [NG-1:0] caught_mask;
  int n_chk = 0, n_fail = 0;
  exp_t q[$];
  int px = 0, py = 0;
  int gx[NG], gy[NG], gd[NG];
  int m_lives = LV, m_mode = 0, m_left = 0, m_id = 0, m_mask = 0;
  int ppx = 0, ppy = 0, pvld = 0;
  int gpx[NG], gpy[NG], gvld[NG];

  ghost_collision_monitor #(.NUM_GHOSTS(NG), .LIVES(LV), .FREEZE_STEPS(FS)) dut (
    .clk(clk), .reset(reset), .step(step), .restart(restart),
    .player_x(player_x), .player_y(player_y), .ghost_x(ghost_x), .ghost_y(ghost_y),
    .ghost_direction(ghost_direction), .lives(lives), .caught(caught), .caught_id(caught_id),
    .caught_mask(caught_mask), .freeze(freeze), .respawn(respawn), .game_over(game_over)
  );

  always #5 clk = ~clk;

  function automatic void check(string nm, int got, int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d at %0t", nm, got, want, $time);
    end
  endfunction

  task automatic clear_valid();
    pvld = 0;
    for (int i = 0; i < NG; i++) gvld[i] = 0;
  endtask

  task automatic cyc(input logic st, input logic rs, input logic rsti);
    exp_t e;
    int mask, want, low;
    bit rsp, cgt;
    @(negedge clk);
    reset = rsti;
    step = st;
    restart = rs;
    player_x = width_log2'(px);
    player_y = height_log2'(py);
    for (int i = 0; i < NG; i++) begin
      ghost_x[i*width_log2 +: width_log2] = width_log2'(gx[i]);
      ghost_y[i*height_log2 +: height_log2] = height_log2'(gy[i]);
      ghost_direction[2*i +: 2] = 2'(gd[i]);
    end
    rsp = 0;
    cgt = 0;
    if (rsti) begin
      m_lives = LV; m_mode = 0; m_left = 0; m_id = 0; m_mask = 0;
      clear_valid();
    end else if (m_mode == 2) begin
      if (rs) begin
        m_lives = LV; m_mode = 0; rsp = 1;
        clear_valid();
      end
    end else if (m_mode == 1) begin
      if (st) begin
        m_left--;
        if (m_left == 0) begin
          m_mode = 0; rsp = 1;
          clear_valid();
        end
      end
    end else if (st) begin
      mask = 0;
      want = px > ppx ? dir_left : px < ppx ? dir_right : py > ppy ? dir_up : py < ppy ? dir_down : -1;
      for (int i = 0; i < NG; i++) begin
        if (gx[i] == px && gy[i] == py) mask |= 1 << i;
        if (CROSS == 1 && gvld[i] == 1 && pvld == 1 && gpx[i] == px && gpy[i] == py &&
            ppx == gx[i] && ppy == gy[i] && gd[i] == want) mask |= 1 << i;
        gpx[i] = gx[i]; gpy[i] = gy[i]; gvld[i] = 1;
      end
      ppx = px; ppy = py; pvld = 1;
      if (mask != 0) begin
        cgt = 1;
        m_mask = mask;
        low = mask & -mask;
        m_id = $clog2(low);
        m_lives--;
        m_mode = m_lives == 0 ? 2 : 1;
        m_left = FS;
      end
    end
    e.lives = 2'(m_lives);
    e.caught = cgt;
    e.id = 2'(m_id);
    e.mask = NG'(m_mask);
    e.frz = m_mode == 1;
    e.rsp = rsp;
    e.ovr = m_mode == 2;
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        check("lives", lives, e.lives);
        check("caught", caught, e.caught);
        check("caught_id", caught_id, e.id);
        check("caught_mask", caught_mask, e.mask);
        check("freeze", freeze, e.frz);
        check("respawn", respawn, e.rsp);
        check("game_over", game_over, e.ovr);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic far();
    for (int i = 0; i < NG; i++) begin gx[i] = 0; gy[i] = 0; gd[i] = 0; end
  endtask

  initial begin
    far();
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    check("rst_lives", lives, 3);
    check("rst_freeze", freeze, 0);
    cyc(0, 0, 0);
    // single hit, then ghost stays on the tile through the freeze
    px = 140; py = 320; gx[0] = 140; gy[0] = 320;
    cyc(1, 0, 0);
    check("t1_caught", caught, 1);
    check("t1_id", caught_id, 0);
    check("t1_lives", lives, 2);
    check("t1_freeze", freeze, 1);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 0, 0);
      check("frz_nocatch", caught, 0);
      check("frz_lives", lives, 2);
    end
    cyc(1, 0, 0);
    check("t1_respawn", respawn, 1);
    check("t1_unfreeze", freeze, 0);
    far();
    cyc(0, 1, 0);
    check("play_restart_ignored", respawn, 0);
    // two ghosts at once
    gx[1] = 140; gy[1] = 320; gx[3] = 140; gy[3] = 320;
    cyc(1, 0, 0);
    check("t2_mask", caught_mask, 4'b1010);
    check("t2_id", caught_id, 1);
    check("t2_lives", lives, 1);
    far();
    for (int k = 0; k < FS; k++) cyc(1, 0, 0);
    // swap tiles head-on with one life left
    gx[0] = 200; gy[0] = 320; px = 180; py = 320;
    cyc(1, 0, 0);
    gx[0] = 180; gd[0] = dir_left; px = 200;
    cyc(1, 0, 0);
    check("cross_caught", caught, CROSS);
    if (CROSS == 0) begin
      gx[0] = 200;
      cyc(1, 0, 0);
    end
    check("over_flag", game_over, 1);
    check("over_lives", lives, 0);
    check("over_nofreeze", freeze, 0);
    gx[0] = px; gy[0] = py;
    cyc(1, 0, 0);
    check("over_step_ignored", caught, 0);
    cyc(1, 1, 0);
    check("restart_lives", lives, 3);
    check("restart_respawn", respawn, 1);
    check("restart_over", game_over, 0);
    // reset in the middle of a freeze
    cyc(1, 0, 0);
    far();
    cyc(1, 0, 0);
    cyc(0, 0, 1);
    check("midrst_lives", lives, 3);
    check("midrst_freeze", freeze, 0);
    cyc(0, 0, 0);
    for (int k = 0; k < 1500; k++) begin
      logic st, rs, rr;
      st = ($urandom % 4) != 0;
      rs = ($urandom % 6) == 0;
      rr = ($urandom % 150) == 0;
      if (st) begin
        if ($urandom % 2 == 1) px = 100 + 20 * int'($urandom % 6);
        else py = 300 + 20 * int'($urandom % 3);
        for (int i = 0; i < NG; i++) begin
          if ($urandom % 3 == 0) begin
            gx[i] = 100 + 20 * int'($urandom % 6);
            gy[i] = 300 + 20 * int'($urandom % 3);
          end
          gd[i] = int'($urandom % 4);
        end
      end
      cyc(st, rs, rr);
    end
    cyc(0, 0, 0);
    check("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
